// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer peripheral: register offsets, CTRL bit
// positions and the default base address of the 16-byte register window.
package bus_timer_pkg;

    localparam logic [31:0] TMR_BASE_ADDR = 32'hFFFF_F100;

    typedef enum logic [1:0] {
        TMR_CTRL  = 2'd0,
        TMR_PRESC = 2'd1,
        TMR_CMP   = 2'd2,
        TMR_COUNT = 2'd3
    } tmr_reg_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_MATCH = 2;
    localparam int CTRL_IE    = 3;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: emits a one-cycle tick every presc+1 enabled cycles.
// 'en' is the enable value for the coming cycle, so a disabling write clears
// pcnt on its own edge while a tick already due in that cycle still fires.
module bus_timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic               active;
    logic [PRESC_W-1:0] pcnt;

    assign tick = active && (pcnt == presc);

    // pcnt only advances in cycles where the counter was already running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            pcnt   <= '0;
        end else begin
            active <= en;
            if (!en || !active || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped prescaled 32-bit timer with compare register and sticky MATCH.
// Optional registered interrupt output enabled by defining BUS_TIMER_IRQ_EN.
import bus_timer_pkg::*;

module bus_timer #(
    parameter logic [31:0] BASE_ADDR = TMR_BASE_ADDR,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
`ifdef BUS_TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic               in_window;
    tmr_reg_e           reg_sel;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_cmp;
    logic               wr_count;

    logic               ctrl_en;
    logic               ctrl_auto;
    logic               ctrl_ie;
    logic               match_flag;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        cmp;
    logic [31:0]        count;

    logic               en_next;
    logic               tick;
    logic               match_hit;

    assign in_window = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = tmr_reg_e'(addr[3:2]);
    assign wr_ctrl   = wen && in_window && (reg_sel == TMR_CTRL);
    assign wr_presc  = wen && in_window && (reg_sel == TMR_PRESC);
    assign wr_cmp    = wen && in_window && (reg_sel == TMR_CMP);
    assign wr_count  = wen && in_window && (reg_sel == TMR_COUNT);

    assign en_next   = wr_ctrl ? wdata[CTRL_EN] : ctrl_en;

    // A software load of COUNT suppresses match evaluation on that edge
    assign match_hit = tick && (count == cmp) && !wr_count;

    bus_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_next),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            presc     <= '0;
            cmp       <= 32'hFFFF_FFFF;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[CTRL_EN];
                ctrl_auto <= wdata[CTRL_AUTO];
                ctrl_ie   <= wdata[CTRL_IE];
            end
            if (wr_presc) begin
                presc <= wdata[PRESC_W-1:0];
            end
            if (wr_cmp) begin
                cmp <= wdata;
            end
        end
    end

    // Setting MATCH takes priority over a simultaneous write-one-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_flag <= 1'b0;
        end else if (match_hit) begin
            match_flag <= 1'b1;
        end else if (wr_ctrl && wdata[CTRL_MATCH]) begin
            match_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wdata;
        end else if (tick) begin
            if (match_hit && ctrl_auto) begin
                count <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

`ifdef BUS_TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= match_flag && ctrl_ie;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (in_window && (addr[1:0] == 2'b00)) begin
            case (reg_sel)
                TMR_CTRL: begin
                    rdata[CTRL_EN]    = ctrl_en;
                    rdata[CTRL_AUTO]  = ctrl_auto;
                    rdata[CTRL_MATCH] = match_flag;
                    rdata[CTRL_IE]    = ctrl_ie;
                end
                TMR_PRESC: rdata[PRESC_W-1:0] = presc;
                TMR_CMP:   rdata = cmp;
                TMR_COUNT: rdata = count;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: each read pushes its expected value into a
// scoreboard queue that is popped when rdata/irq is sampled mid-cycle.
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_F100;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr  = '0;
    logic        wen   = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
`ifdef BUS_TIMER_IRQ_EN
    logic        irq;
`endif

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wen   (wen),
        .wdata (wdata),
        .rdata (rdata)
`ifdef BUS_TIMER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Every stimulus occupies exactly one clock cycle, starting at a falling edge
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wen   = w;
        wdata = d;
        if (w) begin
            @(posedge clk);
            #1 wen = 1'b0;
        end
    endtask

    task automatic popCompare(input logic [31:0] observed);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", observed, ~observed);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.tag, observed, e.exp);
        end
    endtask

    task automatic readAddr(input string tag, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(a, 1'b0, 32'h0);
        expQ.push_back('{tag, exp});
        #1 popCompare(rdata);
    endtask

    task automatic readReg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        readAddr(tag, BASE | {28'h0, off, 2'b00}, exp);
    endtask

    task automatic writeReg(input logic [1:0] off, input logic [31:0] d);
        applyStimulus(BASE | {28'h0, off, 2'b00}, 1'b1, d);
    endtask

`ifdef BUS_TIMER_IRQ_EN
    task automatic sampleIrq(input string tag, input logic exp);
        applyStimulus(BASE, 1'b0, 32'h0);
        expQ.push_back('{tag, {31'h0, exp}});
        #1 popCompare({31'h0, irq});
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values are visible combinationally while reset is held
        readReg("rst_ctrl", TMR_CTRL, 32'h0);
        readReg("rst_presc", TMR_PRESC, 32'h0);
        readReg("rst_cmp", TMR_CMP, 32'hFFFF_FFFF);
        readReg("rst_count", TMR_COUNT, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        writeReg(TMR_PRESC, 32'hABCD_1234);
        readReg("presc_mask", TMR_PRESC, 32'h0000_1234);
        readAddr("misaligned", BASE | 32'h9, 32'h0);
        readAddr("out_window_rd", 32'hFFFF_F208, 32'h0);
        applyStimulus(32'hFFFF_F20C, 1'b1, 32'h1234);
        readReg("out_window_wr", TMR_COUNT, 32'h0);
        readReg("cmp_default", TMR_CMP, 32'hFFFF_FFFF);

        // Prescale by 4: COUNT after i enabled cycles is i/4
        writeReg(TMR_PRESC, 32'd3);
        writeReg(TMR_COUNT, 32'd0);
        writeReg(TMR_CTRL, 32'h1);
        for (int i = 0; i <= 40; i++) begin
            readReg($sformatf("presc_cnt%0d", i), TMR_COUNT, 32'(i / 4));
        end
        writeReg(TMR_CTRL, 32'h0);

        // Auto-reload at CMP=5, then W1C and W1C-vs-match collision
        writeReg(TMR_PRESC, 32'd0);
        writeReg(TMR_CMP, 32'd5);
        writeReg(TMR_COUNT, 32'd0);
        writeReg(TMR_CTRL, 32'h3);
        for (int i = 0; i <= 7; i++) begin
            readReg($sformatf("auto_cnt%0d", i), TMR_COUNT, 32'(i % 6));
        end
        readReg("auto_match_set", TMR_CTRL, 32'h7);
        writeReg(TMR_CTRL, 32'h7);
        readReg("auto_w1c", TMR_CTRL, 32'h3);
        writeReg(TMR_CTRL, 32'h7);
        readReg("w1c_vs_match", TMR_CTRL, 32'h7);
        readReg("auto_after_coll", TMR_COUNT, 32'd1);

        // COUNT load on a tick edge that would otherwise match
        writeReg(TMR_CTRL, 32'h4);
        writeReg(TMR_COUNT, 32'd5);
        writeReg(TMR_CTRL, 32'h3);
        writeReg(TMR_COUNT, 32'h100);
        readReg("count_wr_wins", TMR_COUNT, 32'h100);
        readReg("count_wr_nomatch", TMR_CTRL, 32'h3);

        // 32-bit wrap with CMP=0x10
        writeReg(TMR_CTRL, 32'h4);
        writeReg(TMR_CMP, 32'h10);
        writeReg(TMR_COUNT, 32'hFFFF_FFFE);
        writeReg(TMR_CTRL, 32'h1);
        for (int i = 0; i <= 3; i++) begin
            readReg($sformatf("wrap_cnt%0d", i), TMR_COUNT, 32'hFFFF_FFFE + 32'(i));
        end
        readReg("wrap_nomatch", TMR_CTRL, 32'h1);
        for (int i = 5; i <= 17; i++) begin
            readReg($sformatf("wrap_cnt%0d", i), TMR_COUNT, 32'hFFFF_FFFE + 32'(i));
        end
        readReg("wrap_pre_match", TMR_CTRL, 32'h1);
        readReg("wrap_match", TMR_CTRL, 32'h5);
        readReg("wrap_after", TMR_COUNT, 32'h12);

        // Asynchronous reset while running
        writeReg(TMR_COUNT, 32'h55);
        readReg("load_55", TMR_COUNT, 32'h55);
        @(negedge clk);
        #2 rst_n = 1'b0;
        readReg("mid_rst_ctrl", TMR_CTRL, 32'h0);
        readReg("mid_rst_presc", TMR_PRESC, 32'h0);
        readReg("mid_rst_cmp", TMR_CMP, 32'hFFFF_FFFF);
        readReg("mid_rst_count", TMR_COUNT, 32'h0);
`ifdef BUS_TIMER_IRQ_EN
        sampleIrq("mid_rst_irq", 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BUS_TIMER_IRQ_EN
        // IRQ follows MATCH&IE one cycle later, and drops one cycle after W1C
        writeReg(TMR_PRESC, 32'd0);
        writeReg(TMR_CMP, 32'd2);
        writeReg(TMR_COUNT, 32'd0);
        writeReg(TMR_CTRL, 32'h9);
        for (int i = 0; i <= 3; i++) begin
            sampleIrq($sformatf("irq_low%0d", i), 1'b0);
        end
        sampleIrq("irq_high", 1'b1);
        readReg("irq_ctrl", TMR_CTRL, 32'hD);
        writeReg(TMR_CTRL, 32'hD);
        sampleIrq("irq_hold", 1'b1);
        sampleIrq("irq_cleared", 1'b0);
        readReg("irq_ctrl_clr", TMR_CTRL, 32'h9);

        writeReg(TMR_CTRL, 32'h4);
        writeReg(TMR_COUNT, 32'd0);
        writeReg(TMR_CTRL, 32'h1);
        for (int i = 0; i <= 5; i++) begin
            sampleIrq($sformatf("irq_ie0_%0d", i), 1'b0);
        end
        readReg("irq_ie0_match", TMR_CTRL, 32'h5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
